// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and size helpers for the nibble-serial adder.
// States and pass-count derivation live here so every user agrees.
package nibble_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  function automatic int cnt_bits(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
// Exposes the carry into bit 3 for signed-overflow detection.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       c3,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0])
            | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign sum = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/sub sequencer reusing one 4-bit CLA slice,
// least-significant nibble first.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf
);

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = cnt_bits(NIB);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and >= 8");
  end

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [3:0] s_sum;
  logic       s_c3;
  logic       s_co;

  cla4_slice u_slice (
    .a   (opa[3:0]),
    .b   (opb[3:0]),
    .ci  (carry),
    .sum (s_sum),
    .c3  (s_c3),
    .co  (s_co)
  );

  assign acc_next = {s_sum, acc[WIDTH-1:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= op_sub ? ~b : b;
            carry <= op_sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          acc   <= acc_next;
          opa   <= opa >> 4;
          opb   <= opb >> 4;
          carry <= s_co;
          cnt   <= cnt + CW'(1);
          // Final pass: publish outputs so they are valid alongside done.
          if (cnt == CW'(NIB - 1)) begin
            result <= acc_next;
            co     <= s_co;
            ovf    <= s_co ^ s_c3;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: transaction-level model plus directed
// literal cases and randomized traffic.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .co     (co),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, co, result} from plain wide arithmetic.
  function automatic logic [33:0] ref_op(input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic sub);
    logic [31:0] yy;
    logic [32:0] s;
    logic        v;
    yy = sub ? ~y : y;
    s  = {1'b0, x} + {1'b0, yy} + 33'(sub);
    v  = (x[31] == yy[31]) && (s[31] != x[31]);
    return {v, s[32], s[31:0]};
  endfunction

  // Model: age counts edges since the accepted start edge (-1 = idle).
  int          age = -1;
  logic [31:0] p_a;
  logic [31:0] p_b;
  logic        p_sub;
  logic [31:0] m_res = '0;
  logic        m_co = 1'b0;
  logic        m_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age   = -1;
      m_res = '0;
      m_co  = 1'b0;
      m_ovf = 1'b0;
    end else if (age < 0) begin
      if (start) begin
        age   = 0;
        p_a   = a;
        p_b   = b;
        p_sub = op_sub;
      end
    end else begin
      age++;
      if (age > NIB) begin
        age = -1;
      end else if (age == NIB) begin
        {m_ovf, m_co, m_res} = ref_op(p_a, p_b, p_sub);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(age >= 0));
    chk("done", 32'(done), 32'(age == NIB));
    chk("result", result, m_res);
    chk("co", 32'(co), 32'(m_co));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  end

  task automatic run_op(input string name,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic sub,
                        input logic poke,
                        input logic [31:0] exp_r,
                        input logic exp_c,
                        input logic exp_v);
    int lat;
    lat = 0;
    @(negedge clk);
    a = x; b = y; op_sub = sub; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (poke && k == 3) begin
        start = 1'b1; a = 32'h1111_1111; b = 32'h1111_1111; op_sub = 1'b0;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom; op_sub = 1'($urandom);
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({name, "_lat"}, 32'(lat), 32'(NIB));
    chk({name, "_res"}, result, exp_r);
    chk({name, "_co"}, 32'(co), 32'(exp_c));
    chk({name, "_ovf"}, 32'(ovf), 32'(exp_v));
    chk({name, "_model"}, m_res, exp_r);
    @(posedge clk);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b1; op_sub = 1'b0;
    a = 32'h1234_5678; b = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 32'd0);

    run_op("add_co", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0,
           32'h0000_0000, 1'b1, 1'b0);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
           32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op("sub_brw", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0,
           32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("busy_ign", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1,
           32'h2345_6789, 1'b0, 1'b0);
    run_op("back2back", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
           32'h0000_0100, 1'b0, 1'b0);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_co", 32'(co), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < NIB + 4; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op("after_abort", 32'h0F0F_0F0F, 32'h00F0_00F0, 1'b0, 1'b0,
           32'h0FFF_0FFF, 1'b0, 1'b0);

    // Random traffic, including starts during busy and done cycles.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      op_sub = 1'($urandom);
      a      = $urandom;
      b      = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (NIB + 4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
